// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Fixed 33-cycle latency: one accept edge, 32 shift-add / restoring shift-subtract steps.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        wr_hi,
    input  logic        wr_lo,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // state | meaning
    // IDLE  | waiting for start; wr_hi/wr_lo load HI/LO
    // CALC  | 32 iterations on unsigned magnitudes
    // DONE  | result just written to HI/LO, done pulse
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateType;

    stateType    state;
    stateType    nextState;
    logic [4:0]  iterCnt;
    logic [63:0] acc;
    logic [63:0] accNext;
    logic [31:0] operandB;
    logic        isDiv;
    logic        negResult;
    logic        negRem;
    logic        divByZero;

    logic        signedOp;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] mulSum;
    logic [33:0] divDiff;
    logic [63:0] prodFinal;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;
    logic [31:0] resHi;
    logic [31:0] resLo;

    assign signedOp = op[0];
    assign negA     = signedOp & busA[31];
    assign negB     = signedOp & busB[31];
    assign magA     = negA ? (~busA + 32'd1) : busA;
    assign magB     = negB ? (~busB + 32'd1) : busB;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operandB} : 33'd0);
        divDiff = {1'b0, acc[63:31]} - {2'b00, operandB};
        accNext = {mulSum, acc[31:1]};
        if (isDiv) begin
            if (divDiff[33]) begin
                accNext = {acc[62:0], 1'b0};
            end else begin
                accNext = {divDiff[31:0], acc[30:0], 1'b1};
            end
        end
    end

    always_comb begin
        prodFinal = negResult ? (~accNext + 64'd1) : accNext;
        quoFinal  = negResult ? (~accNext[31:0] + 32'd1) : accNext[31:0];
        remFinal  = negRem ? (~accNext[63:32] + 32'd1) : accNext[63:32];
        resHi     = prodFinal[63:32];
        resLo     = prodFinal[31:0];
        if (isDiv) begin
            resHi = remFinal;
            resLo = divByZero ? 32'hFFFF_FFFF : quoFinal;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (iterCnt == 5'd0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            iterCnt   <= '0;
            acc       <= '0;
            operandB  <= '0;
            isDiv     <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divByZero <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iterCnt   <= 5'd31;
                        isDiv     <= op[1];
                        negResult <= negA ^ negB;
                        negRem    <= op[1] & negA;
                        divByZero <= op[1] & (busB == 32'd0);
                        if (op[1]) begin
                            acc      <= {32'd0, magA};
                            operandB <= magB;
                        end else begin
                            acc      <= {32'd0, magB};
                            operandB <= magA;
                        end
                    end else begin
                        if (wr_hi) begin
                            HI <= busA;
                        end
                        if (wr_lo) begin
                            LO <= busA;
                        end
                    end
                end
                CALC: begin
                    acc     <= accNext;
                    iterCnt <= iterCnt - 5'd1;
                    if (iterCnt == 5'd0) begin
                        HI <= resHi;
                        LO <= resLo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
